// File: rtl/smash_flit_arbiter_if.sv
// smash_flit_arbiter_if: flit FIFO fan-in and output link bundle.
// master = arbiter side, slave = FIFOs/sink side.
interface smash_flit_arbiter_if #(
  parameter int N_IN      = 4,
  parameter int DATA_SIZE = 32
);
  logic [N_IN*DATA_SIZE-1:0] i_data;
  logic [N_IN-1:0]           i_empty;
  logic [N_IN-1:0]           o_read;
  logic [DATA_SIZE-1:0]      o_data;
  logic                      o_valid;
  logic                      i_ready;
  logic [N_IN-1:0]           o_grant;
  logic                      o_busy;

  modport master (
    input  i_data, i_empty, i_ready,
    output o_read, o_data, o_valid, o_grant, o_busy
  );

  modport slave (
    output i_data, i_empty, i_ready,
    input  o_read, o_data, o_valid, o_grant, o_busy
  );
endinterface

// File: rtl/smash_flit_arbiter.sv
// smash_flit_arbiter: wormhole round-robin switch stage.
// A granted input owns the link until its tail flit transfers.
module smash_flit_arbiter #(
  parameter int N_IN      = 4,
  parameter int DATA_SIZE = 32,
  parameter int TYPE_MSB  = DATA_SIZE - 1
) (
  input logic              i_clk,
  input logic              i_rst,
  smash_flit_arbiter_if.master bus
);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]           state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last_grant;
  logic [N_IN-1:0]      grant;
  logic [N_IN-1:0]      elig;
  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW:0]          sum;
  logic [DATA_SIZE-1:0] cur;
  logic                 valid;
  logic                 xfer;
  logic                 cur_tail;

  // head/single flits at a non-empty FIFO front may win
  always_comb begin
    elig = '0;
    for (int k = 0; k < N_IN; k++) begin
      elig[k] = !bus.i_empty[k] &&
                bus.i_data[k*DATA_SIZE + TYPE_MSB - 1];
    end
  end

  // round-robin scan starting after the last owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int i = 1; i <= N_IN; i++) begin
      sum = {1'b0, last_grant} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_IN)) begin
        sum = sum - (IW+1)'(N_IN);
      end
      if (!win_found && elig[sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IW-1:0];
      end
    end
  end

  // owner's front flit and link handshake
  always_comb begin
    cur      = bus.i_data[owner*DATA_SIZE +: DATA_SIZE];
    valid    = (state == S_BUSY) && !bus.i_empty[owner];
    xfer     = valid && bus.i_ready;
    cur_tail = cur[TYPE_MSB];
  end

  // drive the output link and FIFO pop strobes
  always_comb begin
    bus.o_read = '0;
    if (xfer) begin
      bus.o_read[owner] = 1'b1;
    end
    bus.o_valid = valid;
    bus.o_data  = valid ? cur : '0;
    bus.o_grant = grant;
    bus.o_busy  = (state == S_BUSY);
  end

  // arbitration and packet ownership
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      grant      <= '0;
      last_grant <= IW'(N_IN - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state <= S_BUSY;
            owner <= win_idx;
            grant <= {{(N_IN-1){1'b0}}, 1'b1} << win_idx;
          end
        end
        default: begin
          if (xfer && cur_tail) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= owner;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_smash_flit_arbiter.sv
// tb_smash_flit_arbiter: FIFO models feed the arbiter,
// a scoreboard holds the expected flit order at the sink.
module tb_smash_flit_arbiter;
  logic clk;
  logic rst;

  smash_flit_arbiter_if #(.N_IN(4), .DATA_SIZE(32)) bus ();

  smash_flit_arbiter #(
    .N_IN(4), .DATA_SIZE(32), .TYPE_MSB(31)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  logic [31:0] q [4][$];
  logic [31:0] sb [$];
  int          xlog [$];
  logic [3:0]  hide;
  int          checks;
  int          errors;
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(
    input logic [1:0] t, input int k, input int j
  );
    return {t, 14'd0, 8'(k), 8'(j)};
  endfunction

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      bus.i_empty[k] = (q[k].size() == 0) || hide[k];
      bus.i_data[k*32 +: 32] =
        (q[k].size() != 0) ? q[k][0] : 32'h0;
    end
  endtask

  // FIFO fronts follow pops one step after each clock edge
  always @(posedge clk) begin
    #1;
    refresh();
  end

  // sink/FIFO model: a transfer is decided by what is shown now
  always @(negedge clk) begin
    logic xfer;
    logic [31:0] exp;
    cyc++;
    if (!rst) begin
      xfer = bus.o_valid && bus.i_ready;
      checks++;
      if (bus.o_read !== (xfer ? bus.o_grant : 4'b0)) begin
        errors++;
        $display("FAIL read_strobe got %b want %b",
                 bus.o_read, xfer ? bus.o_grant : 4'b0);
      end
      checks++;
      if (!$onehot0(bus.o_grant)) begin
        errors++;
        $display("FAIL grant_onehot got %b want onehot0",
                 bus.o_grant);
      end
      if (xfer) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit got %h want none",
                   bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            errors++;
            $display("FAIL flit_order got %h want %h",
                     bus.o_data, exp);
          end
        end
        xlog.push_back(cyc);
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.o_read[k] && q[k].size() != 0) begin
          void'(q[k].pop_front());
        end
      end
    end
  end

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic nwait();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    at_drive();
    rst = 1'b1;
    bus.i_ready = 1'b1;
    hide = '0;
    for (int k = 0; k < 4; k++) q[k].delete();
    refresh();
    at_drive();
    at_drive();
    rst = 1'b0;
    sb.delete();
    xlog.delete();
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.o_busy) && n < lim) begin
      nwait();
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.o_busy) begin
      errors++;
      $display("FAIL drain_timeout got %0d left want 0",
               sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_ready = 1'b1;
    hide = '0;
    refresh();
    do_reset();
    nwait();
    checks += 5;
    if (bus.o_grant !== 4'b0) begin
      errors++;
      $display("FAIL rst_grant got %b want 0", bus.o_grant);
    end
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", bus.o_valid);
    end
    if (bus.o_read !== 4'b0) begin
      errors++;
      $display("FAIL rst_read got %b want 0", bus.o_read);
    end
    if (bus.o_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", bus.o_data);
    end
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", bus.o_busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    at_drive();
    q[2].push_back(32'hC000_0001);
    sb.push_back(32'hC000_0001);
    refresh();
    nwait();
    checks++;
    if (bus.o_grant !== 4'b0) begin
      errors++;
      $display("FAIL single_comb_grant got %b want 0",
               bus.o_grant);
    end
    nwait();
    checks += 5;
    if (bus.o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant got %b want 0100",
               bus.o_grant);
    end
    if (bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid got %b want 1", bus.o_valid);
    end
    if (bus.o_data !== 32'hC000_0001) begin
      errors++;
      $display("FAIL single_data got %h want c0000001",
               bus.o_data);
    end
    if (bus.o_read !== 4'b0100) begin
      errors++;
      $display("FAIL single_read got %b want 0100",
               bus.o_read);
    end
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b want 1", bus.o_busy);
    end
    nwait();
    checks += 3;
    if (bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0) begin
      errors++;
      $display("FAIL single_idle got %b/%b want 0/0000",
               bus.o_busy, bus.o_grant);
    end
    if (q[2].size() != 0) begin
      errors++;
      $display("FAIL single_popped got %0d want 0",
               q[2].size());
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_sink got %0d left want 0",
               sb.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ty [3];
    int gap;
    ty = '{2'b01, 2'b00, 2'b10};
    do_reset();
    at_drive();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        q[k].push_back(mk(ty[j], k, j));
        sb.push_back(mk(ty[j], k, j));
      end
    end
    refresh();
    xlog.delete();
    wait_drain(80);
    checks++;
    if (xlog.size() != 12) begin
      errors++;
      $display("FAIL rr_count got %0d want 12", xlog.size());
    end else begin
      for (int i = 1; i < 12; i++) begin
        gap = (i % 3 == 0) ? 2 : 1;
        checks++;
        if (xlog[i] - xlog[i-1] != gap) begin
          errors++;
          $display("FAIL rr_gap%0d got %0d want %0d",
                   i, xlog[i] - xlog[i-1], gap);
        end
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    at_drive();
    q[1].push_back(mk(2'b01, 1, 0));
    q[1].push_back(mk(2'b00, 1, 1));
    q[1].push_back(mk(2'b10, 1, 2));
    for (int j = 0; j < 3; j++) sb.push_back(q[1][j]);
    refresh();
    nwait();
    nwait();
    checks++;
    if (bus.o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL bubble_grant got %b want 0010",
               bus.o_grant);
    end
    at_drive();
    hide[1] = 1'b1;
    q[0].push_back(mk(2'b11, 0, 9));
    sb.push_back(mk(2'b11, 0, 9));
    refresh();
    for (int i = 0; i < 5; i++) begin
      nwait();
      checks += 2;
      if (bus.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL bubble_valid%0d got %b want 0",
                 i, bus.o_valid);
      end
      if (bus.o_grant !== 4'b0010) begin
        errors++;
        $display("FAIL bubble_hold%0d got %b want 0010",
                 i, bus.o_grant);
      end
    end
    at_drive();
    hide = '0;
    refresh();
    wait_drain(40);
  endtask

  task automatic test_stall();
    int pat [5];
    pat = '{1, 0, 0, 1, 1};
    do_reset();
    at_drive();
    q[2].push_back(mk(2'b01, 2, 0));
    q[2].push_back(mk(2'b00, 2, 1));
    q[2].push_back(mk(2'b00, 2, 2));
    q[2].push_back(mk(2'b10, 2, 3));
    for (int j = 0; j < 4; j++) sb.push_back(q[2][j]);
    refresh();
    xlog.delete();
    nwait();
    nwait();
    for (int i = 0; i < 5; i++) begin
      at_drive();
      bus.i_ready = pat[i][0];
      nwait();
      if (pat[i] == 0) begin
        checks += 2;
        if (bus.o_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_valid%0d got %b want 1",
                   i, bus.o_valid);
        end
        if (sb.size() == 0 || bus.o_data !== sb[0]) begin
          errors++;
          $display("FAIL stall_hold%0d got %h want %h",
                   i, bus.o_data, mk(2'b00, 2, 2));
        end
      end
    end
    at_drive();
    bus.i_ready = 1'b1;
    wait_drain(20);
    checks++;
    if (xlog.size() != 4) begin
      errors++;
      $display("FAIL stall_count got %0d want 4", xlog.size());
    end
  endtask

  task automatic test_body_blocked();
    do_reset();
    at_drive();
    q[3].push_back(32'h0000_0055);
    refresh();
    for (int i = 0; i < 10; i++) begin
      nwait();
      checks += 2;
      if (bus.o_grant !== 4'b0 || bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL body_grant%0d got %b want 0000",
                 i, bus.o_grant);
      end
      if (bus.o_read !== 4'b0) begin
        errors++;
        $display("FAIL body_read%0d got %b want 0000",
                 i, bus.o_read);
      end
    end
    checks++;
    if (q[3].size() != 1) begin
      errors++;
      $display("FAIL body_kept got %0d want 1", q[3].size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    at_drive();
    q[1].push_back(mk(2'b01, 1, 0));
    q[1].push_back(mk(2'b00, 1, 1));
    q[1].push_back(mk(2'b00, 1, 2));
    q[1].push_back(mk(2'b10, 1, 3));
    sb.push_back(q[1][0]);
    sb.push_back(q[1][1]);
    refresh();
    xlog.delete();
    n = 0;
    while (xlog.size() < 2 && n < 20) begin
      nwait();
      n++;
    end
    checks++;
    if (xlog.size() != 2) begin
      errors++;
      $display("FAIL mid_progress got %0d want 2", xlog.size());
    end
    at_drive();
    rst = 1'b1;
    bus.i_ready = 1'b0;
    nwait();
    nwait();
    checks += 4;
    if (bus.o_grant !== 4'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_grant got %b want 0000", bus.o_grant);
    end
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_valid got %b want 0", bus.o_valid);
    end
    if (bus.o_read !== 4'b0) begin
      errors++;
      $display("FAIL mid_read got %b want 0000", bus.o_read);
    end
    if (q[1].size() != 2) begin
      errors++;
      $display("FAIL mid_left got %0d want 2", q[1].size());
    end
    at_drive();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    q[2].push_back(mk(2'b11, 2, 7));
    q[0].push_back(mk(2'b11, 0, 7));
    sb.push_back(mk(2'b11, 0, 7));
    sb.push_back(mk(2'b11, 2, 7));
    refresh();
    wait_drain(30);
    checks++;
    if (q[1].size() != 2) begin
      errors++;
      $display("FAIL mid_abandoned got %0d want 2",
               q[1].size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_bubble();
    test_stall();
    test_body_blocked();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
